// File: rtl/pld_scr_pkg.sv
// Shared constants for the pld_scr payload scrambler: rate codes, N_DBPS values,
// field lengths, default seed and FSM state encodings.
package pld_scr_pkg;

    localparam logic [3:0] RATE_6  = 4'b1101;
    localparam logic [3:0] RATE_9  = 4'b1111;
    localparam logic [3:0] RATE_12 = 4'b0101;
    localparam logic [3:0] RATE_18 = 4'b0111;
    localparam logic [3:0] RATE_24 = 4'b1001;
    localparam logic [3:0] RATE_36 = 4'b1011;
    localparam logic [3:0] RATE_48 = 4'b0001;
    localparam logic [3:0] RATE_54 = 4'b0011;

    localparam logic [7:0] NDBPS_6  = 8'd24;
    localparam logic [7:0] NDBPS_9  = 8'd36;
    localparam logic [7:0] NDBPS_12 = 8'd48;
    localparam logic [7:0] NDBPS_18 = 8'd72;
    localparam logic [7:0] NDBPS_24 = 8'd96;
    localparam logic [7:0] NDBPS_36 = 8'd144;
    localparam logic [7:0] NDBPS_48 = 8'd192;
    localparam logic [7:0] NDBPS_54 = 8'd216;

    localparam int SERVICE_LEN = 16;
    localparam int TAIL_LEN    = 6;

    localparam logic [6:0] SEED_DEF_VAL = 7'h5D;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SERVICE = 3'd1;
    localparam logic [2:0] ST_DATA    = 3'd2;
    localparam logic [2:0] ST_TAIL    = 3'd3;
    localparam logic [2:0] ST_PAD     = 3'd4;

    // Seed sequence never visits 0, which would lock the LFSR
    function automatic logic [6:0] next_seed(input logic [6:0] s);
        return (s == 7'h7F) ? 7'h01 : s + 7'h01;
    endfunction

endpackage

// File: rtl/pld_scr_lfsr.sv
// scr_lfsr: 7-bit x^7+x^4+1 scrambler LFSR with synchronous load and advance.
module scr_lfsr (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [6:0] seed,
    input  logic       adv,
    output logic       fb
);

    logic [6:0] s;

    assign fb = s[6] ^ s[3];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s <= '0;
        end else if (load) begin
            s <= seed;
        end else if (adv) begin
            s <= {s[5:0], fb};
        end
    end

endmodule

// File: rtl/pld_scr.sv
// pld_scr: builds and scrambles the DATA field (SERVICE, PSDU, tail, pad), one bit per clock.
// Optional macro PLD_SCR_AUTO_SEED_EN replaces the seed port with an internal rolling seed.
module pld_scr
    import pld_scr_pkg::*;
#(
    parameter logic [6:0] SEED_DEF = SEED_DEF_VAL,
    parameter int          LEN_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [3:0]       rate,
    input  logic [6:0]       seed,
    input  logic             di,
    input  logic             di_vld,
    output logic             di_rdy,
    output logic             dout,
    output logic             do_vld,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // state   | meaning
    // IDLE    | waiting for a legal start
    // SERVICE | 16 scrambled zeros
    // DATA    | scrambling accepted PSDU bits, stalls on !di_vld
    // TAIL    | 6 unscrambled zeros, LFSR keeps running
    // PAD     | scrambled zeros until the symbol counter wraps

    localparam int CNT_W = LEN_W + 3;

    logic [2:0]       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [7:0]       sc, sc_nxt;
    logic [7:0]       ndbps_q, ndbps_dec;
    logic [LEN_W-1:0] len_q;
    logic             rate_ok, seed_ok, start_ok;
    logic [6:0]       seed_use;
    logic             emit, bit_in, scr_en, fin, accept, fb;

    always_comb begin
        ndbps_dec = '0;
        rate_ok   = 1'b1;
        case (rate)
            RATE_6:  ndbps_dec = NDBPS_6;
            RATE_9:  ndbps_dec = NDBPS_9;
            RATE_12: ndbps_dec = NDBPS_12;
            RATE_18: ndbps_dec = NDBPS_18;
            RATE_24: ndbps_dec = NDBPS_24;
            RATE_36: ndbps_dec = NDBPS_36;
            RATE_48: ndbps_dec = NDBPS_48;
            RATE_54: ndbps_dec = NDBPS_54;
            default: rate_ok   = 1'b0;
        endcase
    end

`ifdef PLD_SCR_AUTO_SEED_EN
    logic [6:0] seed_q;
    logic       unused_seed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seed_q <= SEED_DEF;
        end else if (fin) begin
            seed_q <= next_seed(seed_q);
        end
    end

    assign seed_use    = seed_q;
    assign seed_ok     = 1'b1;
    assign unused_seed = ^seed;
`else
    logic unused_seed_def;

    assign seed_use        = seed;
    assign seed_ok         = |seed;
    assign unused_seed_def = ^SEED_DEF;
`endif

    assign start_ok = rate_ok && (len != '0) && seed_ok;
    assign busy     = (state != ST_IDLE) || done;
    assign di_rdy   = (state == ST_DATA);
    assign sc_nxt   = (sc == ndbps_q - 8'd1) ? 8'd0 : sc + 8'd1;

    scr_lfsr u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .seed (seed_use),
        .adv  (emit),
        .fb   (fb)
    );

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        emit    = 1'b0;
        bit_in  = 1'b0;
        scr_en  = 1'b1;
        fin     = 1'b0;
        accept  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !busy && start_ok) begin
                    accept  = 1'b1;
                    state_d = ST_SERVICE;
                    cnt_d   = CNT_W'(SERVICE_LEN - 1);
                end
            end
            ST_SERVICE: begin
                emit = 1'b1;
                if (cnt == '0) begin
                    state_d = ST_DATA;
                    cnt_d   = {len_q, 3'b000} - CNT_W'(1);
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (di_vld) begin
                    emit   = 1'b1;
                    bit_in = di;
                    if (cnt == '0) begin
                        state_d = ST_TAIL;
                        cnt_d   = CNT_W'(TAIL_LEN - 1);
                    end else begin
                        cnt_d = cnt - CNT_W'(1);
                    end
                end
            end
            ST_TAIL: begin
                emit   = 1'b1;
                scr_en = 1'b0;
                if (cnt == '0) begin
                    // Tail landing exactly on a symbol boundary skips PAD
                    if (sc_nxt == 8'd0) begin
                        state_d = ST_IDLE;
                        fin     = 1'b1;
                    end else begin
                        state_d = ST_PAD;
                    end
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            ST_PAD: begin
                emit = 1'b1;
                if (sc_nxt == 8'd0) begin
                    state_d = ST_IDLE;
                    fin     = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            sc      <= '0;
            ndbps_q <= '0;
            len_q   <= '0;
            dout    <= 1'b0;
            do_vld  <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            do_vld <= emit;
            dout   <= emit & (scr_en ? (bit_in ^ fb) : bit_in);
            done   <= fin;
            if (accept) begin
                len_q   <= len;
                ndbps_q <= ndbps_dec;
                sc      <= '0;
            end else if (emit) begin
                sc <= sc_nxt;
            end
            if (start && !busy) begin
                err <= !start_ok;
            end
        end
    end

endmodule
